// File: rtl/eim_bus_master.sv
// eim_bus_master: single-outstanding req/rsp to timed async register-bus
// cycles with programmable setup/strobe/hold and optional DTACK wait.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   req_valid/ready     request handshake (ready = idle)
//   req_write/addr/     request direction, address, write data,
//   req_wdata/be        active-high byte enables
//   rsp_valid/rdata/err one-cycle completion, read data, DTACK timeout
//   bus_addr/dout/doe   pad address, write data, data output enable
//   bus_din             pad read data
//   bus_be_n/as         active-low byte enables, address strobe
//   bus_rs_n/ws_n       read/write strobes, active-low
//   bus_dtack_n         responder acknowledge (pre-synchronised)
module eim_bus_master #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int DTACK_EN    = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_dout,
  output logic                bus_doe,
  input  logic [DATA_W-1:0]   bus_din,
  output logic [DATA_W/8-1:0] bus_be_n,
  output logic                bus_as,
  output logic                bus_rs_n,
  output logic                bus_ws_n,
  input  logic                bus_dtack_n
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [7:0]      r_phase;
  logic [7:0]      r_tmo;
  logic            r_write;
  logic [BE_W-1:0] r_be_n;
  logic [DATA_W-1:0] r_cap;
  logic            r_to;

  logic            w_accept;
  logic            w_min_done;
  logic            w_timeout;
  logic            w_wr;
  logic [BE_W-1:0] w_be_src;
  logic            w_as;
  logic            w_rs_n;
  logic            w_ws_n;
  logic            w_doe;
  logic [BE_W-1:0] w_be_n;
  logic            w_valid;
  logic            w_ready;

  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_min_done = (r_phase == STROBE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (req_valid) w_nxt = S_SETUP;
      S_SETUP:
        if (r_phase == SETUP_LAST) w_nxt = S_STROBE;
      S_STROBE:
        // Minimum strobe first; then optionally wait for DTACK,
        // with r_tmo counting the extra cycles spent waiting.
        if (w_min_done) begin
          if (DTACK_EN == 0 || !bus_dtack_n) begin
            w_nxt = S_HOLD;
          end else if (r_tmo == TMO_LAST) begin
            w_nxt     = S_HOLD;
            w_timeout = 1'b1;
          end
        end
      S_HOLD:
        if (r_phase == HOLD_LAST) w_nxt = S_DONE;
      S_DONE:
        w_nxt = S_IDLE;
      default:
        w_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the
  // pads change on the same edge the FSM enters a state. On the
  // accept edge the request fields are not yet latched, so take them
  // straight from the request.
  always_comb begin
    w_wr     = w_accept ? req_write : r_write;
    w_be_src = w_accept ? ~req_be : r_be_n;
    w_as     = 1'b0;
    w_rs_n   = 1'b1;
    w_ws_n   = 1'b1;
    w_doe    = 1'b0;
    w_be_n   = '1;
    w_valid  = 1'b0;
    w_ready  = 1'b0;
    unique case (w_nxt)
      S_IDLE:
        w_ready = 1'b1;
      S_SETUP, S_HOLD: begin
        w_as   = 1'b1;
        w_doe  = w_wr;
        w_be_n = w_be_src;
      end
      S_STROBE: begin
        w_as   = 1'b1;
        w_doe  = w_wr;
        w_be_n = w_be_src;
        w_rs_n = w_wr;
        w_ws_n = ~w_wr;
      end
      S_DONE:
        w_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
      r_tmo   <= '0;
      r_cap   <= '0;
      r_to    <= 1'b0;
    end else begin
      if (w_nxt != r_state) begin
        r_phase <= '0;
        r_tmo   <= '0;
      end else if (r_state == S_STROBE && w_min_done) begin
        r_tmo <= r_tmo + 8'd1;
      end else if (r_state != S_IDLE) begin
        r_phase <= r_phase + 8'd1;
      end
      // Capture on the edge that closes the last low-strobe cycle.
      if (r_state == S_STROBE && w_nxt == S_HOLD) begin
        r_cap <= w_timeout ? '0 : bus_din;
        r_to  <= w_timeout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      bus_addr  <= '0;
      bus_dout  <= '0;
      bus_doe   <= 1'b0;
      bus_be_n  <= '1;
      bus_as    <= 1'b0;
      bus_rs_n  <= 1'b1;
      bus_ws_n  <= 1'b1;
      r_write   <= 1'b0;
      r_be_n    <= '1;
    end else begin
      req_ready <= w_ready;
      rsp_valid <= w_valid;
      bus_doe   <= w_doe;
      bus_be_n  <= w_be_n;
      bus_as    <= w_as;
      bus_rs_n  <= w_rs_n;
      bus_ws_n  <= w_ws_n;
      if (w_accept) begin
        bus_addr <= req_addr;
        r_write  <= req_write;
        r_be_n   <= ~req_be;
        if (req_write) bus_dout <= req_wdata;
      end
      if (w_nxt == S_DONE) begin
        rsp_err <= r_to;
        if (!r_write) rsp_rdata <= r_cap;
      end
    end
  end

endmodule

// File: tb/tb_eim_bus_master.sv
// tb_eim_bus_master: vector table, random and hand sequences checked
// against a cycle-numbered waveform model of the bus master.
module tb_eim_bus_master;

  localparam int S = 2;
  localparam int H = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_write;
  logic [23:0] a_req_addr, a_bus_addr;
  logic [31:0] a_req_wdata, a_rsp_rdata, a_bus_dout, a_bus_din;
  logic [3:0]  a_req_be, a_bus_be_n;
  logic        a_rsp_valid, a_rsp_err, a_bus_doe;
  logic        a_bus_as, a_bus_rs_n, a_bus_ws_n, a_bus_dtack_n;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [23:0] b_req_addr, b_bus_addr;
  logic [31:0] b_req_wdata, b_rsp_rdata, b_bus_dout, b_bus_din;
  logic [3:0]  b_req_be, b_bus_be_n;
  logic        b_rsp_valid, b_rsp_err, b_bus_doe;
  logic        b_bus_as, b_bus_rs_n, b_bus_ws_n, b_bus_dtack_n;

  eim_bus_master u_a (
    .clk(clk), .rst(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_write(a_req_write), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .bus_addr(a_bus_addr),
    .bus_dout(a_bus_dout), .bus_doe(a_bus_doe),
    .bus_din(a_bus_din), .bus_be_n(a_bus_be_n),
    .bus_as(a_bus_as), .bus_rs_n(a_bus_rs_n),
    .bus_ws_n(a_bus_ws_n), .bus_dtack_n(a_bus_dtack_n)
  );

  eim_bus_master #(.DTACK_EN(1), .TIMEOUT_CYC(10)) u_b (
    .clk(clk), .rst(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .bus_addr(b_bus_addr),
    .bus_dout(b_bus_dout), .bus_doe(b_bus_doe),
    .bus_din(b_bus_din), .bus_be_n(b_bus_be_n),
    .bus_as(b_bus_as), .bus_rs_n(b_bus_rs_n),
    .bus_ws_n(b_bus_ws_n), .bus_dtack_n(b_bus_dtack_n)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;
  logic [31:0] last_rd = '0;

  typedef struct {
    logic        ready, ast, rs_n, ws_n, doe, rv, err;
    logic [3:0]  be_n;
    logic [23:0] addr;
    logic [31:0] dout, rdata;
  } obs_t;

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] din;
    logic [3:0]  exp_be_n;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit bad(input logic as_i,
                             input logic rs_i,
                             input logic ws_i);
    return (!rs_i && !ws_i) || ((!rs_i || !ws_i) && !as_i);
  endfunction

  always @(negedge clk) begin
    if (bad(a_bus_as, a_bus_rs_n, a_bus_ws_n) ||
        bad(b_bus_as, b_bus_rs_n, b_bus_ws_n))
      viol <= viol + 1;
  end

  function automatic obs_t get_obs(input bit sel);
    obs_t o;
    if (sel) begin
      o.ready = b_req_ready; o.ast = b_bus_as;
      o.rs_n = b_bus_rs_n; o.ws_n = b_bus_ws_n;
      o.doe = b_bus_doe; o.rv = b_rsp_valid;
      o.err = b_rsp_err; o.be_n = b_bus_be_n;
      o.addr = b_bus_addr; o.dout = b_bus_dout;
      o.rdata = b_rsp_rdata;
    end else begin
      o.ready = a_req_ready; o.ast = a_bus_as;
      o.rs_n = a_bus_rs_n; o.ws_n = a_bus_ws_n;
      o.doe = a_bus_doe; o.rv = a_rsp_valid;
      o.err = a_rsp_err; o.be_n = a_bus_be_n;
      o.addr = a_bus_addr; o.dout = a_bus_dout;
      o.rdata = a_rsp_rdata;
    end
    return o;
  endfunction

  task automatic set_req(input bit sel, input bit v,
                         input bit wr,
                         input logic [23:0] addr,
                         input logic [31:0] wdata,
                         input logic [3:0] be);
    if (sel) begin
      b_req_valid = v; b_req_write = wr;
      b_req_addr = addr; b_req_wdata = wdata;
      b_req_be = be;
    end else begin
      a_req_valid = v; a_req_write = wr;
      a_req_addr = addr; a_req_wdata = wdata;
      a_req_be = be;
    end
  endtask

  task automatic set_pins(input bit sel,
                          input logic [31:0] din,
                          input logic dt);
    if (sel) begin
      b_bus_din = din; b_bus_dtack_n = dt;
    end else begin
      a_bus_din = din; a_bus_dtack_n = dt;
    end
  endtask

  task automatic wait_ready(input bit sel, input string tag);
    int k;
    obs_t o;
    k = 0;
    @(negedge clk);
    o = get_obs(sel);
    while (!o.ready && k < 30) begin
      @(negedge clk);
      o = get_obs(sel);
      k++;
    end
    chk({tag, " ready_wait"}, o.ready, 1);
  endtask

  // One full transaction; slen is the expected strobe length and
  // dt_from the first cycle with DTACK low (0 = never).
  task automatic run(input bit sel, input bit wr,
                     input logic [23:0] addr,
                     input logic [31:0] wdata,
                     input logic [3:0] be,
                     input logic [31:0] din,
                     input int slen, input int dt_from,
                     input logic [3:0] exp_be_n,
                     input logic [31:0] exp_rdata,
                     input bit exp_err,
                     input string tag);
    int t_end;
    bit in_as, in_stb;
    logic [31:0] d;
    obs_t o;
    string p;
    t_end = S + slen + H;
    wait_ready(sel, tag);
    set_req(sel, 1, wr, addr, wdata, be);
    for (int c = 1; c <= t_end + 2; c++) begin
      @(negedge clk);
      if (c == 1) set_req(sel, 0, 0, '0, '0, '0);
      in_as  = (c <= t_end);
      in_stb = (c > S) && (c <= S + slen);
      if (c == S + slen) d = din;
      else if (in_stb) d = din ^ 32'h0F0F_0F0F;
      else d = 32'hFFFF_FFFF;
      set_pins(sel, d, !(dt_from != 0 && c >= dt_from));
      o = get_obs(sel);
      p = $sformatf("%s c%0d", tag, c);
      chk({p, " as"}, o.ast, in_as);
      chk({p, " rs_n"}, o.rs_n, !(in_stb && !wr));
      chk({p, " ws_n"}, o.ws_n, !(in_stb && wr));
      chk({p, " doe"}, o.doe, in_as && wr);
      chk({p, " be_n"}, o.be_n, in_as ? exp_be_n : 4'hF);
      chk({p, " rsp_valid"}, o.rv, c == t_end + 1);
      chk({p, " ready"}, o.ready, c == t_end + 2);
      if (in_as) chk({p, " addr"}, o.addr, addr);
      if (in_as && wr) chk({p, " dout"}, o.dout, wdata);
      if (c == t_end + 1) begin
        chk({p, " rdata"}, o.rdata, exp_rdata);
        chk({p, " err"}, o.err, exp_err);
      end
    end
    set_pins(sel, 32'hFFFF_FFFF, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bit wr;
    logic [23:0] ad;
    logic [31:0] wd, dn;
    logic [3:0] be;
    bit rv_seen;

    tbl[0] = '{1'b1, 24'h000010, 32'hDEADBEEF, 4'hF,
               32'h0, 4'h0, 32'h0};
    tbl[1] = '{1'b0, 24'h000020, 32'h0, 4'hF,
               32'h12345678, 4'h0, 32'h12345678};
    tbl[2] = '{1'b1, 24'h000030, 32'h01020304, 4'b0101,
               32'h0, 4'b1010, 32'h12345678};
    tbl[3] = '{1'b0, 24'hFFFFFF, 32'h0, 4'h0,
               32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5};
    tbl[4] = '{1'b0, 24'h000001, 32'h0, 4'h8,
               32'h00000000, 4'h7, 32'h0};
    tbl[5] = '{1'b1, 24'h800000, 32'hFFFFFFFF, 4'h0,
               32'h0, 4'hF, 32'h0};

    rst_n = 1'b0;
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    set_pins(0, 32'hFFFF_FFFF, 1'b1);
    set_pins(1, 32'hFFFF_FFFF, 1'b1);

    @(negedge clk);
    chk("reset ready", a_req_ready, 1);
    chk("reset rsp_valid", a_rsp_valid, 0);
    chk("reset rdata", a_rsp_rdata, 0);
    chk("reset err", a_rsp_err, 0);
    chk("reset addr", a_bus_addr, 0);
    chk("reset dout", a_bus_dout, 0);
    chk("reset doe", a_bus_doe, 0);
    chk("reset be_n", a_bus_be_n, 4'hF);
    chk("reset as", a_bus_as, 0);
    chk("reset rs_n", a_bus_rs_n, 1);
    chk("reset ws_n", a_bus_ws_n, 1);
    chk("reset b ready", b_req_ready, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
          tbl[i].be, tbl[i].din, 4, 0, tbl[i].exp_be_n,
          tbl[i].exp_rdata, 0, $sformatf("vec%0d", i));
      last_rd = tbl[i].exp_rdata;
    end

    for (int i = 0; i < 20; i++) begin
      wr = 1'($urandom_range(0, 1));
      ad = 24'($urandom);
      wd = $urandom;
      dn = $urandom;
      be = 4'($urandom);
      run(0, wr, ad, wd, be, dn, 4, 0, ~be,
          wr ? last_rd : dn, 0, $sformatf("rnd%0d", i));
      if (!wr) last_rd = dn;
    end

    // Back-to-back: write then read with req_valid held high.
    wait_ready(0, "b2b");
    set_req(0, 1, 1, 24'h000100, 32'hA1B2C3D4, 4'hF);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) set_req(0, 1, 0, 24'h000200, 32'h0, 4'h3);
      if (c == 11) set_req(0, 0, 0, '0, '0, '0);
      a_bus_din = (c == 16) ? 32'h5A5A0001 : 32'hFFFF_FFFF;
      chk($sformatf("b2b c%0d as", c), a_bus_as,
          (c >= 1 && c <= 8) || (c >= 11 && c <= 18));
      chk($sformatf("b2b c%0d rsp_valid", c), a_rsp_valid,
          c == 9 || c == 19);
      chk($sformatf("b2b c%0d ws_n", c), a_bus_ws_n,
          !(c >= 3 && c <= 6));
      chk($sformatf("b2b c%0d rs_n", c), a_bus_rs_n,
          !(c >= 13 && c <= 16));
      if (c == 11) begin
        chk("b2b addr2", a_bus_addr, 24'h000200);
        chk("b2b be_n2", a_bus_be_n, 4'hC);
      end
      if (c == 19) chk("b2b rdata", a_rsp_rdata, 32'h5A5A0001);
    end
    a_bus_din = 32'hFFFF_FFFF;

    // Reset asserted during cycle 4 of a write.
    wait_ready(0, "rst");
    set_req(0, 1, 1, 24'h000300, 32'h55AA55AA, 4'hF);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) set_req(0, 0, 0, '0, '0, '0);
    end
    chk("rst pre ws_n", a_bus_ws_n, 0);
    rst_n = 1'b0;
    #1;
    chk("rst ws_n", a_bus_ws_n, 1);
    chk("rst as", a_bus_as, 0);
    chk("rst doe", a_bus_doe, 0);
    chk("rst be_n", a_bus_be_n, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    rv_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a_rsp_valid) rv_seen = 1'b1;
    end
    chk("rst no rsp_valid", rv_seen, 0);
    chk("rst ready", a_req_ready, 1);
    chk("rst as idle", a_bus_as, 0);
    last_rd = '0;

    run(0, 0, 24'h000400, 32'h0, 4'hF, 32'h0BADF00D, 4, 0,
        4'h0, 32'h0BADF00D, 0, "post_rst");

    // DTACK instance: timeout, late DTACK read, early DTACK write.
    run(1, 0, 24'h0000A0, 32'h0, 4'hF, 32'h77777777, 14, 0,
        4'h0, 32'h0, 1, "dt_tmo");
    run(1, 0, 24'h0000B0, 32'h0, 4'hF, 32'hCAFEF00D, 7, 9,
        4'h0, 32'hCAFEF00D, 0, "dt_rd");
    run(1, 1, 24'h0000C0, 32'h13572468, 4'h6, 32'h0, 4, 3,
        4'h9, 32'hCAFEF00D, 0, "dt_wr");

    chk("strobe invariant", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eim_bus_master.md
Name: eim_bus_master

Overview:
- Initiator side of the ARM/CPLD asynchronous register bus. The slave side decodes AS, RS_n, WS_n, BE_n, address and data on FPGA_CLK1 after synchronisation.
- This block generates those cycles from the FPGA. It converts a single-outstanding request/response handshake into timed bus cycles with programmable setup, strobe and hold, plus an optional DTACK wait.
- It drives the PIO expansion header or another FPGA's register-file slave, and is used as a loopback master for slave bring-up.

Parameters:
- ADDR_W, 24, address width.
- DATA_W, 32, data width. Must be 32, giving 4 byte lanes.
- SETUP_CYC, 2, cycles AS is high with address valid before the strobe. Range 1..255.
- STROBE_CYC, 4, minimum cycles RS_n/WS_n is low. Range 1..255.
- HOLD_CYC, 2, cycles after the strobe rises that AS, address and write data stay valid. Range 1..255.
- DTACK_EN, 0, 1 = extend the strobe until bus_dtack_n is low.
- TIMEOUT_CYC, 255, maximum extra strobe cycles waiting for DTACK before an error. Range 1..255.

Ports:
- clk  in  1  system clock (FPGA_CLK1, 100 MHz).
- rst  in  1  asynchronous, active-low reset (SYS_RST_N).
- req_valid  in  1  request present.
- req_ready  out  1  block idle; a request is accepted when req_valid and req_ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  cycle address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables, active-high.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  read data. Valid with rsp_valid on reads; holds its last value otherwise.
- rsp_err  out  1  DTACK timeout. Valid with rsp_valid.
- bus_addr  out  ADDR_W  registered address.
- bus_dout  out  32  write data to the pad.
- bus_doe  out  1  data pad output enable, high = FPGA drives.
- bus_din  in  32  data from the pad.
- bus_be_n  out  4  byte enables, active-low.
- bus_as  out  1  address strobe, active-high.
- bus_rs_n  out  1  read strobe, active-low.
- bus_ws_n  out  1  write strobe, active-low.
- bus_dtack_n  in  1  responder acknowledge, active-low. Externally synchronised.

Behaviour:
- Reset values: req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, bus_addr 0, bus_dout 0, bus_doe 0, bus_be_n 4'hF, bus_as 0, bus_rs_n 1, bus_ws_n 1.
- All bus and response outputs are registered; nothing is combinational from the inputs.
- Reset mid-cycle: all strobes deassert and bus_doe clears immediately (asynchronous). No rsp_valid is issued for the aborted cycle.
- FSM states are IDLE, SETUP, STROBE, HOLD, DONE. An 8-bit phase counter and an 8-bit timeout counter drive the transitions.
- IDLE: req_ready=1. On accept (edge 0), latch addr, wdata, ~be and write, then go to SETUP.
- SETUP: for cycles 1..SETUP_CYC, bus_as=1 and address/BE are valid. For writes, bus_doe=1 and bus_dout=wdata from cycle 1. Then go to STROBE.
- STROBE: the strobe for the latched direction (RS_n for reads, WS_n for writes) is low for STROBE_CYC cycles.
  - DTACK_EN=1: after the minimum, the strobe stays low until bus_dtack_n is sampled low. This allows at most TIMEOUT_CYC extra cycles; if exceeded, set err and leave STROBE.
  - DTACK_EN=0: bus_dtack_n is ignored.
- Read capture: bus_din is captured into the read-data register on the clock edge that ends STROBE, i.e. the last low-strobe cycle. On timeout the captured value is 0.
- HOLD: strobe high, AS still 1, address, BE and write data/doe held for HOLD_CYC cycles.
- DONE (one cycle):
  - bus_as=0, bus_doe=0, bus_be_n=F, rsp_valid=1, rsp_rdata/rsp_err updated.
  - req_ready stays 0 this cycle. Next state is IDLE.
- Latency with DTACK_EN=0: AS rises at cycle 1, strobe low at cycles SETUP+1..SETUP+STROBE, rsp_valid at cycle SETUP+STROBE+HOLD+1. Defaults give cycle 9.
- Bus idle gap: DONE plus IDLE guarantee at least 2 cycles of AS=0 between back-to-back cycles.
- RS_n and WS_n are never low simultaneously and are never low while AS=0.
- req_* inputs are ignored outside IDLE.
- req_be=0 still runs a full cycle with bus_be_n=F.

Test Plan:
- Write, defaults: addr 0x000010, wdata 0xDEADBEEF, be 4'hF. Expect AS high at cycles 1-8, WS_n low at cycles 3-6, doe high at cycles 1-8, RS_n always 1, rsp_valid at cycle 9 with err=0.
- Read, defaults: bus_din=0x12345678 during the strobe and 0xFFFFFFFF elsewhere. Expect RS_n low at cycles 3-6, rsp_rdata=0x12345678, doe=0 throughout.
- Byte enables: write with be=4'b0101. Expect bus_be_n=4'b1010 during cycles 1-8 and 4'hF otherwise.
- DTACK_EN=1: responder asserts bus_dtack_n low 7 cycles into the strobe. Expect the strobe low for 7 cycles, the read captured on the final cycle, and rsp_valid at cycle 12. With DTACK held high and TIMEOUT_CYC=10, expect rsp_err=1, rsp_rdata=0 and the strobe released after 14 cycles.
- Back-to-back: req_valid held high with 2 queued requests. Expect the second accepted on the cycle after rsp_valid, AS low for exactly 2 cycles between the two, and no strobe overlap.
- Reset mid-cycle: rst low during cycle 4 of a write. Expect WS_n=1, AS=0, doe=0 immediately, no rsp_valid, and req_ready=1 after release.
